// File: rtl/encoder_pkg.sv
// Shared types for the spike encoder: FSM state enum, spike-time code type
// and the no-spike code, all at the default 8-cycle gamma period.
package encoder_pkg;

  localparam int ENC_TIME_PERIOD = 8;
  localparam int ENC_TW          = $clog2(ENC_TIME_PERIOD) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } enc_state_t;

  typedef logic [ENC_TW-1:0] spike_time_t;

  // MSB set marks "no spike"; the low time bits are don't-care and held at 0.
  localparam spike_time_t NO_SPIKE = {1'b1, {(ENC_TW-1){1'b0}}};

endpackage

// File: rtl/spike_time_quantizer.sv
// One pixel -> one rank-order spike-time code. Brighter pixels get earlier
// times; pixels below THRESH get the no-spike code (MSB set, time bits 0).
module spike_time_quantizer #(
  parameter int TIME_PERIOD = 8,
  parameter int PIX_BITS    = 8,
  parameter int THRESH      = 64,
  parameter int TW          = $clog2(TIME_PERIOD) + 1
) (
  input  logic [PIX_BITS-1:0] pix_i,
  output logic [TW-1:0]       code_o
);

  // Number of low pixel bits dropped when mapping intensity onto time slots.
  localparam int SB = PIX_BITS - $clog2(TIME_PERIOD);
  // One extra bit so a threshold equal to 2**PIX_BITS still compares correctly.
  localparam logic [PIX_BITS:0] THRESH_L = THRESH[PIX_BITS:0];

  // (~pix) >> SB keeps exactly the top TW-1 inverted bits, so slice them directly.
  always_comb begin
    code_o = {1'b0, ~pix_i[PIX_BITS-1:SB]};
    if ({1'b0, pix_i} < THRESH_L) begin
      code_o = {1'b1, {(TW-1){1'b0}}};
    end
  end

endmodule

// File: rtl/spike_encoder.sv
// Frame-to-volley encoder and gamma-cycle time base.
// Accepts a pixel frame via valid/ready, holds its encoded spike times for one
// full gamma cycle while time_val counts 0..TIME_PERIOD-1, and chains frames
// with no bubble. time_val parks at TIME_PERIOD while idle.
// Optional feature: define SPIKE_ENCODER_DBUF_EN to add a one-frame shadow
// buffer so the next frame can be taken at any point during a run.
module spike_encoder
  import encoder_pkg::*;
#(
  parameter  int NUM_SPIKES  = 16,
  parameter  int TIME_PERIOD = 8,
  parameter  int PIX_BITS    = 8,
  parameter  int THRESH      = 64,
  localparam int TW          = $clog2(TIME_PERIOD) + 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM_SPIKES-1:0][PIX_BITS-1:0] in_pixels,
  output logic [NUM_SPIKES-1:0][TW-1:0]       spike_times,
  output logic [TW-1:0]                       time_val,
  output logic                                volley_start,
  output logic                                busy
);

  localparam logic [TW-1:0] IDLE_TIME     = TW'(TIME_PERIOD);
  localparam logic [TW-1:0] LAST_TIME     = TW'(TIME_PERIOD - 1);
  localparam logic [TW-1:0] NO_SPIKE_CODE = {1'b1, {(TW-1){1'b0}}};

  logic [NUM_SPIKES-1:0][TW-1:0] enc_codes;
  logic [NUM_SPIKES-1:0][TW-1:0] act_q, act_d;
  enc_state_t                    state_q, state_d;
  logic [TW-1:0]                 time_q, time_d;
  logic                          last_cycle;
  logic                          accept;
`ifdef SPIKE_ENCODER_DBUF_EN
  logic [NUM_SPIKES-1:0][TW-1:0] shadow_q, shadow_d;
  logic                          shadow_full_q, shadow_full_d;
`endif

  // Frames are encoded on the way in, so only codes are ever stored.
  generate
    for (genvar gi = 0; gi < NUM_SPIKES; gi++) begin : g_quant
      spike_time_quantizer #(
        .TIME_PERIOD (TIME_PERIOD),
        .PIX_BITS    (PIX_BITS),
        .THRESH      (THRESH),
        .TW          (TW)
      ) u_quant (
        .pix_i  (in_pixels[gi]),
        .code_o (enc_codes[gi])
      );
    end
  endgenerate

  assign last_cycle   = (state_q == RUN) && (time_q == LAST_TIME);
  assign spike_times  = act_q;
  assign time_val     = time_q;
  assign busy         = (state_q == RUN);
  assign volley_start = (state_q == RUN) && (time_q == '0);

  // Ready generation, next-state and datapath selection for the IDLE/RUN FSM.
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    act_d   = act_q;
`ifdef SPIKE_ENCODER_DBUF_EN
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    in_ready      = !rst && ((state_q == IDLE) || !shadow_full_q);
`else
    in_ready      = !rst && ((state_q == IDLE) || last_cycle);
`endif
    accept = in_valid && in_ready;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          time_d  = '0;
          act_d   = enc_codes;
        end
      end
      RUN: begin
        if (last_cycle) begin
`ifdef SPIKE_ENCODER_DBUF_EN
          if (shadow_full_q) begin
            // Shadow drains to active; a same-cycle accept refills it.
            time_d        = '0;
            act_d         = shadow_q;
            shadow_full_d = accept;
            if (accept) begin
              shadow_d = enc_codes;
            end
          end else
`endif
          if (accept) begin
            time_d = '0;
            act_d  = enc_codes;
          end else begin
            state_d = IDLE;
            time_d  = IDLE_TIME;
            act_d   = {NUM_SPIKES{NO_SPIKE_CODE}};
          end
        end else begin
          time_d = time_q + TW'(1);
`ifdef SPIKE_ENCODER_DBUF_EN
          if (accept) begin
            shadow_d      = enc_codes;
            shadow_full_d = 1'b1;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
        time_d  = IDLE_TIME;
        act_d   = {NUM_SPIKES{NO_SPIKE_CODE}};
      end
    endcase
  end

  // State and code registers; reset drops the active volley and any shadow frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      time_q  <= IDLE_TIME;
      act_q   <= {NUM_SPIKES{NO_SPIKE_CODE}};
`ifdef SPIKE_ENCODER_DBUF_EN
      shadow_full_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      act_q   <= act_d;
`ifdef SPIKE_ENCODER_DBUF_EN
      shadow_full_q <= shadow_full_d;
`endif
    end
  end

`ifdef SPIKE_ENCODER_DBUF_EN
  // Shadow payload needs no reset; shadow_full_q alone says whether it is live.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end
`endif

endmodule

// File: tb/tb_spike_encoder.sv
// Scoreboard bench for spike_encoder at default parameters. The stimulus side
// pushes the hand-tabulated codes of every accepted frame; a monitor pops one
// entry per volley_start and checks codes, stability and the time base.
module tb_spike_encoder;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [15:0][7:0]  in_pixels;
  logic [15:0][3:0]  spike_times;
  logic [3:0]        time_val;
  logic              volley_start;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];

  localparam logic [63:0] ALL_NOSPIKE = {16{4'h8}};

  // Hand-computed encodings at THRESH=64, 8 slots: code = (255-pix)/32, <64 -> 8.
  int pix_tab[8]  = '{255, 200, 128, 64, 63, 0, 100, 160};
  int code_tab[8] = '{0,   1,   3,   5,  8,  8, 4,   2};

  spike_encoder dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pixels    (in_pixels),
    .spike_times  (spike_times),
    .time_val     (time_val),
    .volley_start (volley_start),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] frame_pix(input int k);
    logic [127:0] r;
    for (int ch = 0; ch < 16; ch++) r[ch*8 +: 8] = 8'(pix_tab[(ch + k) % 8]);
    return r;
  endfunction

  function automatic logic [63:0] frame_codes(input int k);
    logic [63:0] r;
    for (int ch = 0; ch < 16; ch++) r[ch*4 +: 4] = 4'(code_tab[(ch + k) % 8]);
    return r;
  endfunction

  // Present frame k0, k0+1, ... (one per cycle) until accepted; returns cycles stalled.
  task automatic offer(input int k0, input int budget, output int waited);
    int k;
    bit got;
    k = k0;
    got = 1'b0;
    waited = 0;
    in_valid = 1'b1;
    while (!got && waited <= budget) begin
      in_pixels = frame_pix(k);
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
      end else begin
        waited++;
        @(posedge clk); #1;
        k++;
      end
    end
    if (got) begin
      exp_q.push_back(frame_codes(k));
      @(posedge clk); #1;
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: frame %0d not accepted within %0d cycles", k0, budget);
    end
    in_valid = 1'b0;
    $display("offer k0=%0d accepted k=%0d after %0d stall cycles", k0, k, waited);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", {63'd0, busy}, 64'd0);
  endtask

  // Monitor: one scoreboard pop per volley, then per-cycle stability checks.
  initial begin : monitor
    logic [63:0] cur;
    logic [3:0]  prev_t;
    cur = ALL_NOSPIKE;
    prev_t = 4'd8;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (volley_start) begin
          chk("vs_time_zero", {60'd0, time_val}, 64'd0);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_volley: got %h expected no volley", spike_times);
          end else begin
            cur = exp_q.pop_front();
            chk("volley_codes", spike_times, cur);
            $display("volley start codes=%h", spike_times);
          end
        end else if (busy) begin
          chk("codes_stable", spike_times, cur);
          chk("time_step", {60'd0, time_val}, {60'd0, prev_t + 4'd1});
        end else begin
          chk("idle_time", {60'd0, time_val}, 64'd8);
          chk("idle_codes", spike_times, ALL_NOSPIKE);
        end
        prev_t = time_val;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int w;
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    in_pixels = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_time_val", {60'd0, time_val}, 64'd8);
    chk("rst_codes", spike_times, ALL_NOSPIKE);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_vstart", {63'd0, volley_start}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // Single frame: full time base then back to idle
    offer(0, 4, w);
    chk("single_wait", 64'(w), 64'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("single_time", {60'd0, time_val}, 64'(k));
      chk("single_vstart", {63'd0, volley_start}, (k == 0) ? 64'd1 : 64'd0);
      chk("single_busy", {63'd0, busy}, 64'd1);
    end
    @(negedge clk);
    chk("single_end_time", {60'd0, time_val}, 64'd8);
    chk("single_end_busy", {63'd0, busy}, 64'd0);
    chk("single_end_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // Back-to-back: B presented from A's time_val = 2
    offer(1, 4, w);
    repeat (2) begin @(posedge clk); #1; end
    offer(2, 12, w);
`ifdef SPIKE_ENCODER_DBUF_EN
    chk("b2b_b_wait", 64'(w), 64'd0);
    offer(3, 12, w);
    chk("b2b_c_wait", 64'(w), 64'd5);
`else
    chk("b2b_b_wait", 64'(w), 64'd5);
    @(negedge clk);
    chk("b2b_b_time0", {60'd0, time_val}, 64'd0);
    chk("b2b_b_vstart", {63'd0, volley_start}, 64'd1);
`endif
    wait_idle();
    @(posedge clk); #1;

    // Stall: frame offered from time_val = 4 while pixels change every cycle
    offer(4, 4, w);
    repeat (4) begin @(posedge clk); #1; end
    offer(5, 12, w);
`ifdef SPIKE_ENCODER_DBUF_EN
    chk("stall_wait", 64'(w), 64'd0);
`else
    chk("stall_wait", 64'(w), 64'd3);
`endif
    wait_idle();
    @(posedge clk); #1;

    // Reset at time_val = 4 (with shadow full when double-buffered)
    offer(6, 4, w);
`ifdef SPIKE_ENCODER_DBUF_EN
    offer(7, 4, w);
    chk("rst_shadow_wait", 64'(w), 64'd0);
`endif
    n = 0;
    while (time_val != 4'd4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reach_time4", {60'd0, time_val}, 64'd4);
    rst = 1'b1;
    #1;
    chk("midrst_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    chk("midrst_time", {60'd0, time_val}, 64'd8);
    chk("midrst_codes", spike_times, ALL_NOSPIKE);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
`ifdef SPIKE_ENCODER_DBUF_EN
    void'(exp_q.pop_back());
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_ready", {63'd0, in_ready}, 64'd1);
    repeat (12) @(negedge clk);
    chk("after_rst_busy", {63'd0, busy}, 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
